// File: rtl/ps2_dev_tx_pkg.sv
// Shared definitions for the PS/2 device transmitter: frame layout, FSM states
// and the frame builder.
package ps2_dev_tx_pkg;

    localparam int FRAME_BITS    = 11;
    localparam int BIT_START     = 0;
    localparam int BIT_PAR       = 9;
    localparam int BIT_STOP      = 10;
    // Two synchroniser cycles plus one grace cycle before a low clock counts as inhibit.
    localparam int INHIBIT_GRACE = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_SEND_HI,
        ST_SEND_LO,
        ST_DONE
    } state_e;

    // Bit 0 is sent first: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Small synchronous byte queue with occupancy count; power-of-two depth.
module ps2_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   cnt_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_dev_tx.sv
// PS/2 device-side transmitter: queues bytes and serialises each into an 11-bit
// open-drain frame, backing off and retrying the whole byte if the host inhibits.
module ps2_dev_tx
    import ps2_dev_tx_pkg::*;
#(
    parameter int HALF_CYC   = 1250,
    parameter int IDLE_CYC   = 2500,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_dat_i,
    output logic                          ps2_clk_drv_o,
    output logic                          ps2_dat_drv_o,
    output logic                          busy_o,
    output logic                          abort_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);
    localparam int            HW        = $clog2(HALF_CYC + 1);
    localparam int            IW        = $clog2(IDLE_CYC + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_CYC - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);

    state_e                  state_q, state_d;
    logic [3:0]              bit_q, bit_d;
    logic [HW-1:0]           half_q, half_d;
    logic [IW-1:0]           idle_q, idle_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic                    abort_q, abort_d;
    logic [1:0]              clk_sync_q, dat_sync_q;
    logic                    clk_s, dat_s;
    logic                    fifo_pop, fifo_full, fifo_empty;
    logic [7:0]              fifo_head;

    ps2_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (tx_valid_i && tx_ready_o),
        .data_i  (tx_data_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .cnt_o   (fifo_cnt_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_sync_q <= 2'b00;
            dat_sync_q <= 2'b00;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
        end
    end

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            half_q  <= '0;
            idle_q  <= '0;
            frame_q <= '1;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            idle_q  <= idle_d;
            frame_q <= frame_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        half_d   = half_q;
        idle_d   = idle_q;
        frame_d  = frame_q;
        abort_d  = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_WAIT_IDLE;
                    idle_d  = '0;
                end
            end
            ST_WAIT_IDLE: begin
                // Host inhibit or request-to-send keeps restarting the idle window.
                if (clk_s && dat_s) begin
                    if (idle_q == IDLE_LAST) begin
                        state_d = ST_SEND_HI;
                        bit_d   = 4'(BIT_START);
                        half_d  = '0;
                        idle_d  = '0;
                        frame_d = build_frame(fifo_head);
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end else begin
                    idle_d = '0;
                end
            end
            ST_SEND_HI: begin
                if (!clk_s && (half_q >= HW'(INHIBIT_GRACE)) && (bit_q <= 4'(BIT_PAR))) begin
                    state_d = ST_WAIT_IDLE;
                    idle_d  = '0;
                    abort_d = 1'b1;
                end else if (half_q == HALF_LAST) begin
                    state_d = ST_SEND_LO;
                    half_d  = '0;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            ST_SEND_LO: begin
                if (half_q == HALF_LAST) begin
                    half_d = '0;
                    if (bit_q == 4'(BIT_STOP)) begin
                        state_d  = ST_DONE;
                        fifo_pop = 1'b1;
                    end else begin
                        state_d = ST_SEND_HI;
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            ST_DONE: begin
                idle_d  = '0;
                state_d = fifo_empty ? ST_IDLE : ST_WAIT_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Drive decodes come straight from registered state so async reset releases at once.
    assign ps2_clk_drv_o = (state_q == ST_SEND_LO);
    assign ps2_dat_drv_o = ((state_q == ST_SEND_HI) || (state_q == ST_SEND_LO)) && !frame_q[bit_q];
    assign busy_o        = (state_q == ST_SEND_HI) || (state_q == ST_SEND_LO) || (state_q == ST_DONE);
    assign abort_o       = abort_q;
    assign tx_ready_o    = !fifo_full;

endmodule
